// File: rtl/task_seq_pkg.sv
// Shared types and constants for the renderer stage sequencer.
// Holds the sequencer state encoding and default frame pacing values.
package task_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        FRAME_WAIT
    } seq_state_e;

    localparam int FRAME_CNT_W          = 16;
    localparam int DEFAULT_FRAME_CYCLES = 1700000;

endpackage

// File: rtl/task_seq_frame_limiter.sv
// Loadable saturating down-counter that flags when it has drained to zero.
// Used for frame pacing; also meant for VGA pacing logic.
module frame_limiter
    import task_seq_pkg::*;
#(
    parameter int WIDTH = 21
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/task_sequencer.sv
// Stage sequencer: runs init tasks once, then loops frame tasks forever.
// Optional per-task watchdog is built when TASK_TIMEOUT_EN is defined.
module task_sequencer
    import task_seq_pkg::*;
#(
    parameter int NUM_TASKS       = 4,
    parameter int FIRST_LOOP_TASK = 1,
    parameter int FRAME_CYCLES    = DEFAULT_FRAME_CYCLES,
    parameter int TIMEOUT_CYCLES  = 1048576,
    parameter int IDX_W           = $clog2(NUM_TASKS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_TASKS-1:0]   task_done,
    output logic [NUM_TASKS-1:0]   task_start,
    output logic [IDX_W-1:0]       active_task,
    output logic                   active_valid,
    output logic                   init_done,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   timeout_err
);

    localparam int LIM_LOAD = (FRAME_CYCLES > 1) ? FRAME_CYCLES - 1 : 0;
    localparam int LIM_W    = (LIM_LOAD > 1) ? $clog2(LIM_LOAD + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TASKS - 1);
    localparam logic [IDX_W-1:0] LOOP_IDX = IDX_W'(FIRST_LOOP_TASK);

    seq_state_e             state_d, state_q;
    logic [IDX_W-1:0]       idx_d, idx_q;
    logic [NUM_TASKS-1:0]   task_start_d, task_start_q;
    logic                   active_valid_d, active_valid_q;
    logic                   init_done_d, init_done_q;
    logic                   frame_tick_d, frame_tick_q;
    logic [FRAME_CNT_W-1:0] frame_count_d, frame_count_q;
    logic                   timeout_err_d, timeout_err_q;
    logic                   lim_load;
    logic                   lim_zero;
    logic                   wd_expired;
    logic                   advance;

`ifdef TASK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_d, wd_q;

    // Watchdog: zero outside WAIT, so it restarts on every WAIT entry.
    always_comb begin
        wd_d = '0;
        if (state_q == WAIT) begin
            wd_d = wd_q + 1'b1;
        end
    end

    // Watchdog register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign wd_expired = (state_q == WAIT)
                     && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog a task may wait forever.
    assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    assign advance = task_done[idx_q] || wd_expired;

    // Next state, task index and registered output values.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        frame_tick_d  = 1'b0;
        frame_count_d = frame_count_q;
        init_done_d   = init_done_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (advance) begin
                    if (!task_done[idx_q]) begin
                        timeout_err_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        frame_tick_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                        idx_d         = LOOP_IDX;
                        state_d       = FRAME_WAIT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = enable ? START : IDLE;
                    end
                end
            end
            FRAME_WAIT: begin
                if (lim_zero && enable) begin
                    state_d = START;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        lim_load = (state_d == START) && (idx_d == LOOP_IDX);
        if (lim_load) begin
            init_done_d = 1'b1;
        end
        task_start_d = '0;
        if (state_d == START) begin
            task_start_d[idx_d] = 1'b1;
        end
        active_valid_d = (state_d == START) || (state_d == WAIT);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            task_start_q   <= '0;
            active_valid_q <= 1'b0;
            init_done_q    <= 1'b0;
            frame_tick_q   <= 1'b0;
            frame_count_q  <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            task_start_q   <= task_start_d;
            active_valid_q <= active_valid_d;
            init_done_q    <= init_done_d;
            frame_tick_q   <= frame_tick_d;
            frame_count_q  <= frame_count_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    frame_limiter #(
        .WIDTH(LIM_W)
    ) u_limiter (
        .clock     (clock),
        .reset     (reset),
        .load      (lim_load),
        .load_value(LIM_W'(LIM_LOAD)),
        .zero      (lim_zero)
    );

    assign task_start   = task_start_q;
    assign active_task  = idx_q;
    assign active_valid = active_valid_q;
    assign init_done    = init_done_q;
    assign frame_tick   = frame_tick_q;
    assign frame_count  = frame_count_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Randomised bench for task_sequencer against an event-timing model.
// Define TASK_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
module tb_task_sequencer;

    localparam int N   = 4;
    localparam int FLT = 1;
    localparam int FC  = 20;
    localparam int TO  = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic [N-1:0]  task_done = '0;
    logic [N-1:0]  task_start;
    logic [1:0]    active_task;
    logic          active_valid;
    logic          init_done;
    logic          frame_tick;
    logic [15:0]   frame_count;
    logic          timeout_err;

    task_sequencer #(
        .NUM_TASKS      (N),
        .FIRST_LOOP_TASK(FLT),
        .FRAME_CYCLES   (FC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .task_done   (task_done),
        .task_start  (task_start),
        .active_task (active_task),
        .active_valid(active_valid),
        .init_done   (init_done),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: timing of expected events, in absolute cycle numbers.
    int start_at, start_idx;
    bit running;
    int run_idx, start_cyc, done_cyc;
    bit pending;
    int next_idx, ready_at, tick_at, head_cyc;
    int frames, err_from;
    bit init_seen;
    int last_h1, obs_t0, pause_left;
    bit hung = 0;
    bit did_mid = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_task_start"}, task_start, 0);
        check({tag, "_active_task"}, active_task, 0);
        check({tag, "_active_valid"}, active_valid, 0);
        check({tag, "_init_done"}, init_done, 0);
        check({tag, "_frame_tick"}, frame_tick, 0);
        check({tag, "_frame_count"}, frame_count, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    task automatic model_reset();
        running    = 0;
        pending    = 1;
        next_idx   = 0;
        ready_at   = cyc;
        start_at   = -1;
        start_idx  = 0;
        tick_at    = -1;
        head_cyc   = -1000;
        init_seen  = 0;
        frames     = 0;
        err_from   = -1;
        last_h1    = -1;
        obs_t0     = 0;
        pause_left = 0;
    endtask

    // Check cycle cyc, then drive its inputs and advance the model.
    task automatic step();
        logic [N-1:0] exp_ts;
        logic [N-1:0] td;
        int d;
        bit done_ev;
        exp_ts = '0;
        if (start_at == cyc) begin
            exp_ts[start_idx] = 1'b1;
            running   = 1;
            run_idx   = start_idx;
            start_cyc = cyc;
            if (cyc < 60) d = 3;
            else if (cyc < 150) d = 1;
            else d = $urandom_range(1, 5);
`ifdef TASK_TIMEOUT_EN
            if (cyc >= 200 && !hung && start_idx == 2) begin
                d = 1000;
                hung = 1;
            end
`endif
            done_cyc = cyc + d;
            if (start_idx == FLT) begin
                head_cyc  = cyc;
                init_seen = 1;
            end
        end
        if (tick_at == cyc) frames++;

        check("task_start", task_start, exp_ts);
        check("active_valid", active_valid, running);
        if (running) check("active_task", active_task, run_idx);
        check("init_done", init_done, init_seen);
        check("frame_tick", frame_tick, tick_at == cyc);
        check("frame_count", frame_count, frames[15:0]);
        check("timeout_err", timeout_err, err_from >= 0 && cyc >= err_from);

        if (task_start[0]) obs_t0++;
        if (task_start[1]) begin
            if (last_h1 >= 0) begin
                if (cyc < 150) check("frame_period", cyc - last_h1, FC);
                else check("frame_period_min", (cyc - last_h1) >= FC, 1);
            end
            last_h1 = cyc;
        end

        if (pause_left > 0) begin
            enable = 1'b0;
            pause_left--;
        end else if (cyc >= 150 && $urandom_range(0, 19) == 0) begin
            enable = 1'b0;
            pause_left = $urandom_range(1, 8);
        end else begin
            enable = 1'b1;
        end
        td = (cyc >= 150) ? N'($urandom) : '0;
        if (running) begin
            td[run_idx] = 1'b0;
            if (cyc == start_cyc) td[run_idx] = 1'($urandom_range(0, 1));
            else if (cyc == done_cyc) td[run_idx] = 1'b1;
        end
        task_done = td;

        done_ev = 0;
        if (running && cyc > start_cyc) begin
            if (cyc == done_cyc) begin
                done_ev = 1;
            end
`ifdef TASK_TIMEOUT_EN
            else if (cyc - start_cyc == TO) begin
                done_ev = 1;
                if (err_from < 0) err_from = cyc + 1;
            end
`endif
        end
        if (done_ev) begin
            running = 0;
            pending = 1;
            if (run_idx < N - 1) begin
                next_idx = run_idx + 1;
                ready_at = cyc;
            end else begin
                tick_at  = cyc + 1;
                next_idx = FLT;
                ready_at = (cyc + 1 > head_cyc + FC - 1) ? cyc + 1
                                                         : head_cyc + FC - 1;
            end
        end
        if (pending && cyc >= ready_at && enable) begin
            start_at  = cyc + 1;
            start_idx = next_idx;
            pending   = 0;
        end
    endtask

    initial begin
        reset = 1'b0;
        #3;
        check_all_zero("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        cyc = 0;
        model_reset();
        step();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            cyc++;
            step();
            if (!did_mid && cyc > 400 && running && run_idx == 2
                && cyc > start_cyc) begin
                did_mid = 1;
                #2 reset = 1'b0;
                #1;
                check_all_zero("midrst");
                @(negedge clock);
                cyc++;
                reset = 1'b1;
                model_reset();
                step();
            end
        end
        check("task0_once", obs_t0, 1);
        check("mid_reset_hit", did_mid, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/task_sequencer.md
Name: task_sequencer

Overview:
- Parametrised top-level stage sequencer for the renderer. It generalises the fixed reset/load/draw/raytrace FSM to NUM_TASKS start/done channels.
- Tasks 0..FIRST_LOOP_TASK-1 run once after reset (init phase, e.g. player reset, level load). Tasks FIRST_LOOP_TASK..NUM_TASKS-1 then repeat forever (frame loop, e.g. draw grid, draw player, raytracer).
- A built-in frame limiter enforces a minimum frame period.
- It exports the active task index, which datapath muxes use to grant grid and VGA access. It also adds pause support and a frame counter.

Parameters:
- NUM_TASKS, 4, number of task channels (2..16).
- FIRST_LOOP_TASK, 1, index of the first looped task (0..NUM_TASKS-1).
- FRAME_CYCLES, 1700000, minimum cycles between successive start pulses of task FIRST_LOOP_TASK (0 or 1 = no limit).
- TIMEOUT_CYCLES, 1048576, per-task watchdog limit (used only with TASK_TIMEOUT_EN).
- IDX_W, $clog2(NUM_TASKS), index width (derived).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  high = sequencer may issue the next start; low = pause between tasks
- task_done  in  NUM_TASKS  done pulse/level from each task engine
- task_start  out  NUM_TASKS  one-hot, one-cycle start pulse
- active_task  out  IDX_W  index of task currently started or running
- active_valid  out  1  high in START and WAIT
- init_done  out  1  sticky; set on first start of FIRST_LOOP_TASK
- frame_tick  out  1  one-cycle pulse when task NUM_TASKS-1 completes
- frame_count  out  16  completed frames, wraps at 16'hFFFF -> 0
- timeout_err  out  1  sticky watchdog flag (0 when feature off)

Behaviour:
- Reset (reset low, asynchronous): state IDLE, idx=0, limiter=0.
  - All outputs 0: task_start, active_task, active_valid, init_done, frame_tick, frame_count, timeout_err.
- States: IDLE, START, WAIT, FRAME_WAIT.
- IDLE:
  - enable=1 -> START with the current idx; else stay.
  - IDLE is also the pause state between tasks.
- START (exactly one cycle):
  - task_start[idx]=1; active_valid=1; active_task=idx. Moore outputs, decoded from state.
  - If idx==FIRST_LOOP_TASK: limiter loads FRAME_CYCLES-1 (saturating at 0) and init_done is set.
  - -> WAIT.
- WAIT:
  - active_valid=1; only task_done[idx] is sampled; all other done bits are ignored.
  - task_done[idx] high at cycle t with idx<NUM_TASKS-1: idx++. Go to START at t+1 if enable=1 at t, else IDLE.
  - task_done[idx] high at t with idx==NUM_TASKS-1: frame_tick=1 at t+1, frame_count++, idx=FIRST_LOOP_TASK, -> FRAME_WAIT.
- FRAME_WAIT:
  - active_valid=0.
  - limiter==0 and enable=1 -> START; otherwise stay.
  - The limiter keeps decrementing while paused.
- Limiter:
  - Free-running down-counter; decrements every cycle while nonzero, holds at 0.
  - Period is measured start-to-start of FIRST_LOOP_TASK. A loop longer than FRAME_CYCLES incurs exactly one FRAME_WAIT cycle.
- Latency: done→next start is 1 cycle within a frame. End of frame→loop-head start is at least 1 cycle.
- task_done asserted during START is ignored; it is sampled from the first WAIT cycle.
- Pause: enable only gates new starts. A running task is never aborted.
- Reset mid-task: the sequencer returns to IDLE with idx=0 and restarts the init phase. Task engines share the reset.
- FIRST_LOOP_TASK=0: there is no init phase, and init_done is set on the first start.

Optional Feature:
- Macro: TASK_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYCLES without task_done[idx]: timeout_err is set (sticky until reset) and the sequencer advances exactly as if done had been seen.
- Undefined: no counter; WAIT holds indefinitely; timeout_err is tied 0.

Decomposition:
- Package task_seq_pkg holds:
  - the state enum (IDLE, START, WAIT, FRAME_WAIT);
  - the frame_count width constant (16);
  - a default FRAME_CYCLES constant.
- Sub-module frame_limiter: loadable saturating down-counter.
  - Ports: clock, reset, load, load_value, zero.
  - Reused by the sequencer and by future VGA pacing logic.

Test Plan:
All scenarios use NUM_TASKS=4, FIRST_LOOP_TASK=1, FRAME_CYCLES=20.
- Reset release, enable=1, each done returned 3 cycles after its start -> starts ordered 0,1,2,3,1,2,3,...; init_done rises with the first task_start[1]; task 0 never restarts.
- Fast tasks (done 1 cycle after start) -> task_start[1] pulses are exactly 20 cycles apart; frame_tick is one cycle each frame; frame_count 0→1→2.
- Done for the wrong channel (task_done[3] while idx=1) -> ignored; sequencer stays in WAIT until task_done[1].
- enable dropped while task 2 runs -> task 2 completes, no task_start[3], active_valid=0. Re-assert enable -> task_start[3] the cycle after enable is sampled high.
- reset low mid-WAIT of task 2 -> all outputs 0 immediately (asynchronous); after release, the sequence restarts at task 0.
- TASK_TIMEOUT_EN, TIMEOUT_CYCLES=8, task 2 never done -> timeout_err=1 after 8 WAIT cycles, then task_start[3] issues; timeout_err stays 1.
